// File: rtl/pc_redirect_ctrl_if.sv
// pc_redirect_ctrl_if: redirect sources, fetch-tracking events and redirect/flush outputs
// shared by the exception/branch units, pc_redirect_ctrl and the IF stage.
interface pc_redirect_ctrl_if;
    logic        exc_req;
    logic [31:0] exc_target;
    logic        eret_req;
    logic [31:0] eret_target;
    logic        br_req;
    logic [31:0] br_target;
    logic        inst_req_fire;
    logic        inst_data_ok;
    logic        redirect_ready;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        flush_back;
    logic        flush_front;
    logic        discard_data;
    logic        fetch_block;
    logic        busy;
    modport master (
        output exc_req, exc_target, eret_req, eret_target, br_req, br_target,
               inst_req_fire, inst_data_ok, redirect_ready,
        input  redirect_valid, redirect_pc, flush_back, flush_front, discard_data,
               fetch_block, busy
    );
    modport slave (
        input  exc_req, exc_target, eret_req, eret_target, br_req, br_target,
               inst_req_fire, inst_data_ok, redirect_ready,
        output redirect_valid, redirect_pc, flush_back, flush_front, discard_data,
               fetch_block, busy
    );
endinterface

// File: rtl/pc_redirect_ctrl.sv
// pc_redirect_ctrl: arbitrates fetch-PC redirects, drains in-flight fetches, issues one target PC.
// Optional PC_REDIRECT_BYPASS_EN: zero-latency redirect from IDLE when nothing is in flight.
module pc_redirect_ctrl #(
    parameter int          OUTS_W   = 2,
    parameter logic [31:0] RESET_PC = 32'hBFC00000
) (
    input logic               clk_i,
    input logic               resetn_i,
    pc_redirect_ctrl_if.slave bus
);
    typedef enum logic [1:0] {BOOT, IDLE, DRAIN, ISSUE} state_e;
    typedef enum logic [1:0] {SRC_BOOT, SRC_BR, SRC_ERET, SRC_EXC} src_e;
    localparam logic [OUTS_W-1:0] CNT_MAX = '1;

    state_e            state_q, state_d, go_state;
    src_e              src_q, src_d, req_src;
    logic [31:0]       pc_q, pc_d, req_pc;
    logic [OUTS_W-1:0] cnt_q, cnt_d;
    logic              back_req, any_req, bypass, fire, ok;

    assign fire     = bus.inst_req_fire;
    assign ok       = bus.inst_data_ok;
    assign back_req = bus.exc_req | bus.eret_req;
    assign any_req  = back_req | bus.br_req;
    assign req_src  = bus.exc_req ? SRC_EXC : bus.eret_req ? SRC_ERET : SRC_BR;
    assign req_pc   = bus.exc_req ? bus.exc_target : bus.eret_req ? bus.eret_target : bus.br_target;
    assign cnt_d    = (fire && !ok && cnt_q != CNT_MAX) ? cnt_q + OUTS_W'(1) :
                      (!fire && ok && cnt_q != '0) ? cnt_q - OUTS_W'(1) : cnt_q;
    // Decide on the post-update count so a fetch accepted alongside the request is still drained
    assign go_state = (cnt_d == '0) ? ISSUE : DRAIN;

`ifdef PC_REDIRECT_BYPASS_EN
    assign bypass = state_q == IDLE && any_req && cnt_d == '0;
`else
    assign bypass = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        src_d   = src_q;
        pc_d    = pc_q;
        unique case (state_q)
            BOOT: state_d = ISSUE;
            IDLE: if (any_req) begin
                state_d = (bypass && bus.redirect_ready) ? IDLE : go_state;
                src_d   = req_src;
                pc_d    = req_pc;
            end
            default: begin
                if (state_q == DRAIN && cnt_d == '0) state_d = ISSUE;
                if (state_q == ISSUE && bus.redirect_ready) begin
                    state_d = any_req ? go_state : IDLE;
                    src_d   = any_req ? req_src : src_q;
                    pc_d    = any_req ? req_pc : pc_q;
                end else if (back_req && (src_q == SRC_BR || src_q == SRC_BOOT)) begin
                    state_d = go_state;
                    src_d   = req_src;
                    pc_d    = req_pc;
                end else if (bus.exc_req) begin
                    pc_d = bus.exc_target;
                end
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge resetn_i) begin
        if (!resetn_i) begin
            state_q <= BOOT;
            src_q   <= SRC_BOOT;
            pc_q    <= RESET_PC;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            src_q   <= src_d;
            pc_q    <= pc_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        bus.busy           = state_q != IDLE;
        bus.redirect_valid = state_q == ISSUE || bypass;
        bus.redirect_pc    = bypass ? req_pc : pc_q;
        bus.flush_front    = state_q == DRAIN || state_q == ISSUE || bypass;
        bus.flush_back     = ((state_q == DRAIN || state_q == ISSUE) &&
                              (src_q == SRC_EXC || src_q == SRC_ERET)) || (bypass && back_req);
        bus.discard_data   = state_q == DRAIN && ok;
        bus.fetch_block    = state_q != IDLE || cnt_q == CNT_MAX;
    end
endmodule

// File: tb/tb_pc_redirect_ctrl.sv
// tb_pc_redirect_ctrl: directed checks of boot, arbitration, drain, preemption, hold and reset.
module tb_pc_redirect_ctrl;
    logic clk = 1'b0;
    logic resetn = 1'b1;
    int   checks = 0;
    int   errors = 0;

    pc_redirect_ctrl_if ifc ();
    pc_redirect_ctrl dut (.clk_i(clk), .resetn_i(resetn), .bus(ifc.slave));

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        ifc.exc_req = 0; ifc.exc_target = '0; ifc.eret_req = 0; ifc.eret_target = '0;
        ifc.br_req = 0; ifc.br_target = '0; ifc.inst_req_fire = 0; ifc.inst_data_ok = 0;
        ifc.redirect_ready = 0;
        #1 resetn = 0;
        #2;
        chk("rst_valid", 32'(ifc.redirect_valid), 0);
        chk("rst_pc", ifc.redirect_pc, 32'hBFC00000);
        chk("rst_fetch_block", 32'(ifc.fetch_block), 1);
        chk("rst_busy", 32'(ifc.busy), 1);
        chk("rst_flush_front", 32'(ifc.flush_front), 0);
        chk("rst_flush_back", 32'(ifc.flush_back), 0);
        chk("rst_discard", 32'(ifc.discard_data), 0);
        tick();
        resetn = 1; ifc.redirect_ready = 1;
        tick();
        chk("boot_valid", 32'(ifc.redirect_valid), 1);
        chk("boot_pc", ifc.redirect_pc, 32'hBFC00000);
        tick();
        chk("boot_done_valid", 32'(ifc.redirect_valid), 0);
        chk("boot_done_busy", 32'(ifc.busy), 0);
        chk("boot_done_fetch_block", 32'(ifc.fetch_block), 0);

        ifc.exc_req = 1; ifc.exc_target = 32'hBFC00380;
        tick();
        ifc.exc_req = 0;
        chk("exc_valid", 32'(ifc.redirect_valid), 1);
        chk("exc_pc", ifc.redirect_pc, 32'hBFC00380);
        chk("exc_flush_back", 32'(ifc.flush_back), 1);
        chk("exc_flush_front", 32'(ifc.flush_front), 1);
        tick();
        chk("exc_idle_busy", 32'(ifc.busy), 0);
        chk("exc_idle_flush_back", 32'(ifc.flush_back), 0);

        ifc.inst_data_ok = 1;
        tick();
        ifc.inst_data_ok = 0;
        chk("underflow_fetch_block", 32'(ifc.fetch_block), 0);

        ifc.inst_req_fire = 1;
        tick(); tick();
        ifc.inst_req_fire = 0;
        chk("cnt2_fetch_block", 32'(ifc.fetch_block), 0);
        ifc.br_req = 1; ifc.br_target = 32'h80001000;
        tick();
        ifc.br_req = 0;
        chk("drain_busy", 32'(ifc.busy), 1);
        chk("drain_valid", 32'(ifc.redirect_valid), 0);
        chk("drain_flush_front", 32'(ifc.flush_front), 1);
        chk("drain_flush_back", 32'(ifc.flush_back), 0);
        chk("drain_fetch_block", 32'(ifc.fetch_block), 1);
        ifc.inst_data_ok = 1;
        #1;
        chk("drain_discard1", 32'(ifc.discard_data), 1);
        tick();
        chk("drain_valid2", 32'(ifc.redirect_valid), 0);
        chk("drain_discard2", 32'(ifc.discard_data), 1);
        tick();
        ifc.inst_data_ok = 0;
        #1;
        chk("br_valid", 32'(ifc.redirect_valid), 1);
        chk("br_pc", ifc.redirect_pc, 32'h80001000);
        chk("br_flush_back", 32'(ifc.flush_back), 0);
        chk("br_discard", 32'(ifc.discard_data), 0);
        tick();

        ifc.exc_req = 1; ifc.eret_req = 1; ifc.br_req = 1;
        ifc.eret_target = 32'h80002000;
        tick();
        ifc.exc_req = 0; ifc.eret_req = 0; ifc.br_req = 0;
        chk("pri_exc_pc", ifc.redirect_pc, 32'hBFC00380);
        chk("pri_exc_flush_back", 32'(ifc.flush_back), 1);
        tick();
        ifc.eret_req = 1; ifc.br_req = 1;
        tick();
        ifc.eret_req = 0; ifc.br_req = 0;
        chk("pri_eret_pc", ifc.redirect_pc, 32'h80002000);
        chk("pri_eret_flush_back", 32'(ifc.flush_back), 1);
        tick();

        ifc.inst_req_fire = 1;
        tick();
        ifc.inst_req_fire = 0; ifc.br_req = 1;
        tick();
        ifc.br_req = 0;
        chk("pre_flush_back0", 32'(ifc.flush_back), 0);
        ifc.exc_req = 1;
        tick();
        ifc.exc_req = 0;
        chk("pre_flush_back1", 32'(ifc.flush_back), 1);
        chk("pre_valid0", 32'(ifc.redirect_valid), 0);
        ifc.inst_data_ok = 1;
        tick();
        ifc.inst_data_ok = 0;
        chk("pre_valid1", 32'(ifc.redirect_valid), 1);
        chk("pre_pc", ifc.redirect_pc, 32'hBFC00380);
        tick();

        ifc.redirect_ready = 0; ifc.eret_req = 1;
        tick();
        ifc.eret_req = 0;
        chk("hold_pc1", ifc.redirect_pc, 32'h80002000);
        ifc.br_req = 1; ifc.br_target = 32'h80003000;
        tick();
        ifc.br_req = 0;
        chk("hold_valid", 32'(ifc.redirect_valid), 1);
        chk("hold_pc2", ifc.redirect_pc, 32'h80002000);
        ifc.redirect_ready = 1;
        tick();
        chk("hold_done_busy", 32'(ifc.busy), 0);

        ifc.inst_req_fire = 1;
        tick(); tick(); tick();
        ifc.inst_req_fire = 0;
        chk("full_fetch_block", 32'(ifc.fetch_block), 1);
        chk("full_busy", 32'(ifc.busy), 0);
        ifc.inst_data_ok = 1;
        tick();
        ifc.inst_data_ok = 0;
        chk("full_release", 32'(ifc.fetch_block), 0);

        ifc.br_req = 1;
        tick();
        ifc.br_req = 0;
        chk("mid_drain_busy", 32'(ifc.busy), 1);
        resetn = 0;
        #1;
        chk("mid_rst_pc", ifc.redirect_pc, 32'hBFC00000);
        chk("mid_rst_valid", 32'(ifc.redirect_valid), 0);
        chk("mid_rst_flush_front", 32'(ifc.flush_front), 0);
        chk("mid_rst_busy", 32'(ifc.busy), 1);
        resetn = 1;
        tick(); tick();
        ifc.br_req = 1;
        tick();
        ifc.br_req = 0;
        chk("mid_rst_cnt_cleared", 32'(ifc.redirect_valid), 1);
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
